fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect/kill handling, accepted-instruction counter.
// Optional build macro FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a sticky trap instead of masking them.
module fetch_sequencer #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     imem_req_valid,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [ADDRESS_WIDTH-1:0] if_pc,
  input  logic                     if_ready,
  output logic [31:0]              fetch_count,
  output logic                     misalign_trap
);

  // state | meaning
  // REQ   | request pc_q on imem, waiting for ready
  // WAIT  | request accepted, waiting for its response
  // DRAIN | request accepted but redirected; its response will be dropped
  // HOLD  | instruction presented to decode
  // TRAP  | misaligned redirect seen; frozen until reset
  typedef enum logic [2:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD, S_TRAP} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]              instr_q, instr_d;
  logic [31:0]              count_q, count_d;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     misaligned;
  logic                     redir_ok;
  logic                     redir_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = |redirect_target[1:0];
`else
  logic misalign_unused;
  assign misalign_unused = |redirect_target[1:0];
  assign misaligned      = 1'b0;
`endif

  assign target    = {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
  assign redir_ok  = redirect_valid && !misaligned;
  assign redir_bad = redirect_valid && misaligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) fetch_pc_d = pc_q;
        if (redir_bad) begin
          state_d = S_TRAP;
        end else if (redir_ok) begin
          pc_d = target;
          // a request that went out with the old pc must have its response dropped
          if (imem_req_ready) state_d = S_DRAIN;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir_bad) begin
          state_d = S_TRAP;
        end else if (redir_ok) begin
          pc_d    = target;
          state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          pc_d    = pc_q + ADDRESS_WIDTH'(4);
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (redir_bad) begin
          state_d = S_TRAP;
        end else begin
          if (redir_ok) pc_d = target;
          if (imem_rsp_valid) state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redir_bad) begin
          state_d = S_TRAP;
        end else if (redir_ok) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (if_ready) begin
          count_d = count_q + 32'd1;
          state_d = S_REQ;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == S_HOLD);
  assign if_instr       = instr_q;
  assign if_pc          = fetch_pc_q;
  assign fetch_count    = count_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_trap = (state_q == S_TRAP);
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic [31:0] fetch_count;
  logic        misalign_trap;

  fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .if_ready(if_ready), .fetch_count(fetch_count),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model: an outstanding request (possibly stale), an optionally held instruction, a pc and a counter
  bit          m_init = 0;
  logic [31:0] m_pc, m_fpc, m_instr, m_count;
  bit          m_out, m_stale, m_held, m_trap;

  task automatic model_step(input logic r, input logic rv, input logic [31:0] rt, input logic rdy,
                            input logic rspv, input logic [31:0] rd, input logic ifr);
    logic        mis;
    logic [31:0] tgt;
    if (r) begin
      m_init = 1; m_pc = 32'h0; m_fpc = 32'h0; m_instr = 32'h0000_0013; m_count = 0;
      m_out = 0; m_stale = 0; m_held = 0; m_trap = 0;
      return;
    end
    if (!m_init) return;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis = (rt[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    tgt = {rt[31:2], 2'b00};
    if (m_trap) begin
    end else if (rv && mis) begin
      m_trap = 1; m_held = 0; m_out = 0;
    end else if (m_held) begin
      if (rv) begin m_pc = tgt; m_held = 0; end
      else if (ifr) begin m_count++; m_held = 0; end
    end else if (!m_out) begin
      if (rdy) begin m_fpc = m_pc; m_out = 1; m_stale = rv; end
      if (rv) m_pc = tgt;
    end else if (!m_stale) begin
      if (rspv) begin
        m_out = 0;
        if (rv) m_pc = tgt;
        else begin m_instr = rd; m_pc = m_pc + 4; m_held = 1; end
      end else if (rv) begin
        m_pc = tgt; m_stale = 1;
      end
    end else begin
      if (rv) m_pc = tgt;
      if (rspv) m_out = 0;
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [31:0] rt, input logic rdy,
                       input logic rspv, input logic [31:0] rd, input logic ifr);
    logic exp_req;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_target = rt; imem_req_ready = rdy;
    imem_rsp_valid = rspv; imem_rsp_data = rd; if_ready = ifr;
    if (m_init) begin
      exp_req = !m_out && !m_held && !m_trap;
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check("req_addr", imem_req_addr, m_pc);
      check("if_valid", 32'(if_valid), 32'(m_held));
      if (m_held) begin
        check("if_instr", if_instr, m_instr);
        check("if_pc", if_pc, m_fpc);
      end
      check("fetch_count", fetch_count, m_count);
      check("misalign_trap", 32'(misalign_trap), 32'(m_trap));
    end
    @(posedge clk);
    model_step(r, rv, rt, rdy, rspv, rd, ifr);
    #1;
  endtask

  initial begin
    logic [31:0] cnt0, hi, hp;
    repeat (2) cycle(1, 0, 0, 0, 0, 0, 0);
    // first cycle after reset: requesting RESET_PC
    check("post_rst_req", 32'(imem_req_valid), 32'd1);
    check("post_rst_addr", imem_req_addr, 32'h0);

    // case 1: three back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      check("c1_addr", imem_req_addr, 32'(i * 4));
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h0050_0093, 0);
      if (i == 0) begin
        check("c1_if_pc", if_pc, 32'h0);
        check("c1_if_instr", if_instr, 32'h0050_0093);
        check("c1_if_valid", 32'(if_valid), 32'd1);
      end
      cycle(0, 0, 0, 0, 0, 0, 1);
    end
    check("c1_count", fetch_count, 32'd3);

    // case 2: redirect in WAIT, stale response two cycles later
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 1, 32'h100, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("c2_no_if_valid", 32'(if_valid), 32'd0);
    cycle(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    check("c2_no_if_valid2", 32'(if_valid), 32'd0);
    check("c2_req", 32'(imem_req_valid), 32'd1);
    check("c2_addr", imem_req_addr, 32'h100);

    // case 3: redirect in HOLD with if_ready
    cnt0 = fetch_count;
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h1234_5678, 0);
    cycle(0, 1, 32'h40, 0, 0, 0, 1);
    check("c3_count", fetch_count, cnt0);
    check("c3_addr", imem_req_addr, 32'h40);

    // case 4: decode stalls for 5 cycles
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'hCAFE_0013, 0);
    hi = if_instr; hp = if_pc;
    check("c4_pc", hp, 32'h40);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 1, 32'h0BAD_0BAD, 0);
      check("c4_if_valid", 32'(if_valid), 32'd1);
      check("c4_if_instr", if_instr, hi);
      check("c4_if_pc", if_pc, hp);
      check("c4_req_valid", 32'(imem_req_valid), 32'd0);
    end
    cycle(0, 0, 0, 0, 0, 0, 1);

    // case 5: misaligned redirect
    cycle(0, 1, 32'h102, 0, 0, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("c5_trap", 32'(misalign_trap), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 1, 0, 1);
      check("c5_no_req", 32'(imem_req_valid), 32'd0);
      check("c5_trap_sticky", 32'(misalign_trap), 32'd1);
    end
`else
    check("c5_addr", imem_req_addr, 32'h100);
    check("c5_no_trap", 32'(misalign_trap), 32'd0);
`endif

    // case 6: reset while waiting, response in the first cycle after reset
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 32'h1111_1111, 0);
    check("c6_req", 32'(imem_req_valid), 32'd1);
    check("c6_addr", imem_req_addr, 32'h0);
    check("c6_count", fetch_count, 32'd0);
    cycle(0, 0, 0, 0, 1, 32'h2222_2222, 0);
    check("c6_rsp_ignored", 32'(if_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      t = $urandom();
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      cycle($urandom_range(79) == 0, $urandom_range(7) == 0, t, 1'($urandom()),
            1'($urandom()), $urandom(), 1'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
